// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: FSM state encodings, owner codes and latency bounds for the memory port arbiter.
package mem_port_arbiter_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 15;
  function automatic int clamp_lat(input int lat);
    return lat < MEM_LAT_MIN ? MEM_LAT_MIN : lat > MEM_LAT_MAX ? MEM_LAT_MAX : lat;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;
  logic              dm_req;
  logic              dm_we;
  logic              dm_byte;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;
  logic              dm_stall;
  logic              mem_en;
  logic              mem_we;
  logic              mem_byte;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_byte, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
           mem_en, mem_we, mem_byte, mem_addr, mem_wdata, busy
  );
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_byte, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
           mem_en, mem_we, mem_byte, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// arb_lat_counter: loadable down-counter with zero flag that times the memory WAIT phase.
module arb_lat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  end
  assign zero = cnt == '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and data requesters, one access in flight.
// Define ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_LIMIT consecutive contended data wins.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int MEM_LAT      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int LAT = clamp_lat(MEM_LAT);
  logic [1:0] state;
  logic       owner;
  logic       we_l;
  logic       flushed;
  logic       grant_if;
  logic       owner_req;
  logic       kill;
  logic       lat_zero;
  assign owner_req = owner == OWN_DM ? bus.dm_req : bus.if_req;
  assign kill      = flushed | ~owner_req;
  assign bus.busy     = state != S_IDLE;
  assign bus.if_stall = bus.if_req & ~bus.if_valid & ~rst;
  assign bus.dm_stall = bus.dm_req & ~bus.dm_valid & ~rst;
`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;
  assign grant_if = bus.if_req & (~bus.dm_req | starve_cnt == 4'(STARVE_LIMIT));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_cnt <= '0;
    else if (state == S_IDLE && (bus.if_req || bus.dm_req))
      starve_cnt <= grant_if ? 4'd0 : bus.if_req ? starve_cnt + 4'd1 : starve_cnt;
  end
`else
  assign grant_if = bus.if_req & ~bus.dm_req;
`endif
  arb_lat_counter #(.W(4)) u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (state == S_ISSUE),
    .dec      (state == S_WAIT),
    .load_val (4'(LAT - 1)),
    .zero     (lat_zero)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      owner         <= OWN_IF;
      we_l          <= 1'b0;
      flushed       <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_byte  <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_valid  <= 1'b0;
      bus.dm_valid  <= 1'b0;
      bus.if_rdata  <= '0;
      bus.dm_rdata  <= '0;
    end else begin
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_byte  <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_valid  <= 1'b0;
      bus.dm_valid  <= 1'b0;
      case (state)
        S_IDLE: if (bus.if_req || bus.dm_req) begin
          state         <= S_ISSUE;
          owner         <= grant_if ? OWN_IF : OWN_DM;
          we_l          <= ~grant_if & bus.dm_we;
          flushed       <= 1'b0;
          bus.mem_en    <= 1'b1;
          bus.mem_we    <= ~grant_if & bus.dm_we;
          bus.mem_byte  <= ~grant_if & bus.dm_byte;
          bus.mem_addr  <= grant_if ? bus.if_addr : bus.dm_addr;
          bus.mem_wdata <= grant_if ? '0 : bus.dm_wdata;
        end
        S_ISSUE: begin
          state   <= S_WAIT;
          flushed <= kill;
        end
        S_WAIT: begin
          flushed <= kill;
          if (lat_zero) begin
            state <= S_DONE;
            if (!kill) begin
              if (owner == OWN_IF) begin
                bus.if_rdata <= bus.mem_rdata;
                bus.if_valid <= 1'b1;
              end else begin
                bus.dm_valid <= 1'b1;
                if (!we_l) bus.dm_rdata <= bus.mem_rdata;
              end
            end
          end
        end
        S_DONE: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors for mem_port_arbiter with MEM_LAT=2.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic idle_inputs();
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_byte = 1'b0;
    bus.dm_addr = '0; bus.dm_wdata = '0; bus.mem_rdata = '0;
  endtask
  initial begin
    idle_inputs();
    #1;
    check("rst_busy", 16'(bus.busy), 16'd0);
    check("rst_mem_en", 16'(bus.mem_en), 16'd0);
    check("rst_if_rdata", bus.if_rdata, 16'h0000);
    step(2);
    rst = 1'b0;
    step();
    // fetch only
    bus.if_req = 1'b1; bus.if_addr = 16'h0004;
    #1;
    check("f_stall_c0", 16'(bus.if_stall), 16'd1);
    check("f_busy_c0", 16'(bus.busy), 16'd0);
    step();
    check("f_mem_en_c1", 16'(bus.mem_en), 16'd1);
    check("f_mem_addr_c1", bus.mem_addr, 16'h0004);
    check("f_mem_we_c1", 16'(bus.mem_we), 16'd0);
    step();
    check("f_mem_en_c2", 16'(bus.mem_en), 16'd0);
    check("f_stall_c2", 16'(bus.if_stall), 16'd1);
    step();
    bus.mem_rdata = 16'h1234;
    check("f_valid_c3", 16'(bus.if_valid), 16'd0);
    check("f_stall_c3", 16'(bus.if_stall), 16'd1);
    step();
    check("f_valid_c4", 16'(bus.if_valid), 16'd1);
    check("f_rdata_c4", bus.if_rdata, 16'h1234);
    check("f_stall_c4", 16'(bus.if_stall), 16'd0);
    idle_inputs();
    step();
    check("f_valid_c5", 16'(bus.if_valid), 16'd0);
    check("f_busy_c5", 16'(bus.busy), 16'd0);
    // contention: data load beats fetch
    bus.if_req = 1'b1; bus.if_addr = 16'h0010;
    bus.dm_req = 1'b1; bus.dm_addr = 16'h0200;
    step();
    check("c_mem_en_c1", 16'(bus.mem_en), 16'd1);
    check("c_mem_addr_c1", bus.mem_addr, 16'h0200);
    step(2);
    bus.mem_rdata = 16'h5678;
    step();
    check("c_dm_valid_c4", 16'(bus.dm_valid), 16'd1);
    check("c_dm_rdata_c4", bus.dm_rdata, 16'h5678);
    check("c_if_valid_c4", 16'(bus.if_valid), 16'd0);
    check("c_if_stall_c4", 16'(bus.if_stall), 16'd1);
    bus.dm_req = 1'b0;
    step();
    check("c_busy_c5", 16'(bus.busy), 16'd0);
    step();
    check("c_mem_en_c6", 16'(bus.mem_en), 16'd1);
    check("c_mem_addr_c6", bus.mem_addr, 16'h0010);
    step(2);
    bus.mem_rdata = 16'h9ABC;
    step();
    check("c_if_valid_c9", 16'(bus.if_valid), 16'd1);
    check("c_if_rdata_c9", bus.if_rdata, 16'h9ABC);
    check("c_dm_rdata_c9", bus.dm_rdata, 16'h5678);
    idle_inputs();
    step();
    // byte store
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_byte = 1'b1;
    bus.dm_addr = 16'h0101; bus.dm_wdata = 16'h00AB;
    step();
    check("s_mem_en", 16'(bus.mem_en), 16'd1);
    check("s_mem_we", 16'(bus.mem_we), 16'd1);
    check("s_mem_byte", 16'(bus.mem_byte), 16'd1);
    check("s_mem_addr", bus.mem_addr, 16'h0101);
    check("s_mem_wdata", bus.mem_wdata, 16'h00AB);
    step(2);
    bus.mem_rdata = 16'hFFFF;
    step();
    check("s_dm_valid_c4", 16'(bus.dm_valid), 16'd1);
    check("s_dm_rdata_c4", bus.dm_rdata, 16'h5678);
    idle_inputs();
    step();
    // async reset in cycle 2 of a fetch
    bus.if_req = 1'b1; bus.if_addr = 16'h0020;
    step(2);
    rst = 1'b1;
    #1;
    check("r_busy", 16'(bus.busy), 16'd0);
    check("r_if_rdata", bus.if_rdata, 16'h0000);
    check("r_dm_rdata", bus.dm_rdata, 16'h0000);
    check("r_if_stall", 16'(bus.if_stall), 16'd0);
    step(2);
    check("r_if_valid", 16'(bus.if_valid), 16'd0);
    check("r_mem_en", 16'(bus.mem_en), 16'd0);
    rst = 1'b0;
    step();
    check("r_mem_en_c1", 16'(bus.mem_en), 16'd1);
    check("r_mem_addr_c1", bus.mem_addr, 16'h0020);
    step(2);
    bus.mem_rdata = 16'h4321;
    step();
    check("r_if_valid_c4", 16'(bus.if_valid), 16'd1);
    check("r_if_rdata_c4", bus.if_rdata, 16'h4321);
    idle_inputs();
    step();
    // fetch flushed in cycle 2
    bus.if_req = 1'b1; bus.if_addr = 16'h0030;
    step(2);
    bus.if_req = 1'b0;
    check("x_busy_c2", 16'(bus.busy), 16'd1);
    step();
    bus.mem_rdata = 16'h7777;
    check("x_busy_c3", 16'(bus.busy), 16'd1);
    step();
    check("x_busy_c4", 16'(bus.busy), 16'd1);
    check("x_if_valid_c4", 16'(bus.if_valid), 16'd0);
    check("x_if_rdata_c4", bus.if_rdata, 16'h4321);
    step();
    check("x_busy_c5", 16'(bus.busy), 16'd0);
    idle_inputs();
    step();
    // continuous contention: strict priority, or forced fetch with the starve guard
    bus.if_req = 1'b1; bus.if_addr = 16'h0040;
    bus.dm_req = 1'b1; bus.dm_addr = 16'h0400;
    for (int i = 1; i <= 22; i++) begin
      step();
      check($sformatf("v_mem_en_c%0d", i), 16'(bus.mem_en), 16'(i % 5 == 1));
      if (i % 5 == 1) begin
`ifdef ARB_STARVE_GUARD_EN
        check($sformatf("v_mem_addr_c%0d", i), bus.mem_addr, i == 21 ? 16'h0040 : 16'h0400);
`else
        check($sformatf("v_mem_addr_c%0d", i), bus.mem_addr, 16'h0400);
`endif
      end
    end
    idle_inputs();
    step(6);
    check("end_busy", 16'(bus.busy), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
